// File: rtl/switch_led_controller.sv
// switch_led_controller: debounced multi-switch panel arbitrating events into toggle/blink/chase LED modes.
// Define PRESS_EDGE_EN to fire events on the debounced press instead of the release.
module switch_led_controller #(
  parameter int NUM_SW         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int BLINK_DIV      = 12500000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_LED,
  output logic [1:0]        o_Mode,
  output logic              o_Event
);
  localparam int PW = $clog2(NUM_SW);
  localparam int DW = NUM_SW - 1;
  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  localparam int BW = $clog2(BLINK_DIV);
  typedef enum logic [1:0] {TOGGLE, BLINK, CHASE} mode_t;
  logic [NUM_SW-1:0] sync1, synced, stable, stable_d, pending, edge_evt, gnt;
  logic [CW-1:0] db_cnt [NUM_SW];
  logic [PW-1:0] rr, gnt_idx, pos;
  logic [BW-1:0] blink_cnt;
  logic [DW-1:0] led_state, data_led;
  logic gnt_vld, phase;
  int cand;
  mode_t mode, mode_nx;
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      sync1    <= '0;
      synced   <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < NUM_SW; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= i_Switch;
      synced   <= sync1;
      stable_d <= stable;
      for (int i = 0; i < NUM_SW; i++)
        if (synced[i] == stable[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] == CW'(DEBOUNCE_LIMIT - 1)) begin
          stable[i] <= synced[i];
          db_cnt[i] <= '0;
        end else db_cnt[i] <= db_cnt[i] + CW'(1);
    end
`ifdef PRESS_EDGE_EN
  assign edge_evt = stable & ~stable_d;
`else
  assign edge_evt = stable_d & ~stable;
`endif
  // Scan downward so the candidate closest to rr is the last one to win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = NUM_SW - 1; k >= 0; k--) begin
      cand = int'(rr) + k;
      cand = cand >= NUM_SW ? cand - NUM_SW : cand;
      if (pending[PW'(cand)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(cand);
      end
    end
    gnt = gnt_vld ? NUM_SW'(1) << gnt_idx : '0;
  end
  always_comb begin
    mode_nx = mode;
    if (gnt[NUM_SW-1]) mode_nx = mode == TOGGLE ? BLINK : mode == BLINK ? CHASE : TOGGLE;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) mode <= TOGGLE;
    else mode <= mode_nx;
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      pending   <= '0;
      rr        <= '0;
      led_state <= '0;
      o_Event   <= 1'b0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      pos       <= '0;
    end else begin
      pending   <= (pending & ~gnt) | edge_evt;
      o_Event   <= gnt_vld;
      led_state <= led_state ^ (gnt[DW-1:0] & {DW{mode != CHASE}});
      if (gnt_vld) rr <= gnt_idx == PW'(NUM_SW - 1) ? '0 : gnt_idx + PW'(1);
      if (mode_nx != mode) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
        pos       <= '0;
      end else if (mode != TOGGLE) begin
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
          pos       <= pos == PW'(NUM_SW - 2) ? '0 : pos + PW'(1);
        end else blink_cnt <= blink_cnt + BW'(1);
      end
    end
  assign data_led = mode == TOGGLE ? led_state : mode == BLINK ? led_state & {DW{phase}} : DW'(1) << pos;
  assign o_LED    = {mode != TOGGLE, data_led};
  assign o_Mode   = mode;
endmodule

// File: tb/tb_switch_led_controller.sv
// tb_switch_led_controller: directed vector bench for switch_led_controller (NUM_SW=4, DEBOUNCE_LIMIT=4, BLINK_DIV=8).
module tb_switch_led_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic [3:0] led;
  logic [1:0] mode;
  logic evt;
  int tests = 0;
  int fails = 0;
  int ev_cnt = 0;
  int ev_base = 0;
  typedef struct {
    bit         rst;
    logic [3:0] sw;
    int         n;
    logic [3:0] led;
    logic [1:0] mode;
    logic       evt;
    int         cnt;
  } vec_t;
  vec_t tbl [$];

  switch_led_controller #(.NUM_SW(4), .DEBOUNCE_LIMIT(4), .BLINK_DIV(8)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw), .o_LED(led), .o_Mode(mode), .o_Event(evt)
  );

  always #5 clk = ~clk;
  // Pulses are counted mid-cycle, so a check at cycle N sees pulses from cycles before N.
  always @(negedge clk) if (evt) ev_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    sw = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    ev_base = ev_cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    chk("rst_led", 0, led, 4'b0000);
    chk("rst_mode", 0, mode, 2'd0);
    chk("rst_evt", 0, evt, 1'b0);
    do_reset();
`ifdef PRESS_EDGE_EN
    sw = 4'b0001;
    repeat (7) tick();
    chk("press_early", 0, led, 4'b0000);
    tick();
    chk("press_led", 0, led, 4'b0001);
    chk("press_evt", 0, evt, 1'b1);
    sw = 4'b0000;
    repeat (20) tick();
    chk("release_led", 0, led, 4'b0001);
    chk("release_cnt", 0, ev_cnt - ev_base, 1);
    sw = 4'b0001;
    repeat (8) tick();
    chk("press2_led", 0, led, 4'b0000);
    chk("press2_mode", 0, mode, 2'd0);
`else
    tbl = '{
      // clean release, twice
      '{1'b1, 4'b0001, 10, 4'b0000, 2'd0, 1'b0, 0},
      '{1'b0, 4'b0000,  7, 4'b0000, 2'd0, 1'b0, 0},
      '{1'b0, 4'b0000,  1, 4'b0001, 2'd0, 1'b1, 0},
      '{1'b0, 4'b0000,  1, 4'b0001, 2'd0, 1'b0, 1},
      '{1'b0, 4'b0001, 10, 4'b0001, 2'd0, 1'b0, 1},
      '{1'b0, 4'b0000,  8, 4'b0000, 2'd0, 1'b1, 1},
      '{1'b0, 4'b0000,  2, 4'b0000, 2'd0, 1'b0, 2},
      // bounce rejection
      '{1'b0, 4'b0010,  3, 4'b0000, 2'd0, 1'b0, 2},
      '{1'b0, 4'b0000,  1, 4'b0000, 2'd0, 1'b0, 2},
      '{1'b0, 4'b0010,  2, 4'b0000, 2'd0, 1'b0, 2},
      '{1'b0, 4'b0000, 10, 4'b0000, 2'd0, 1'b0, 2},
      // contention from rr=0, then rr=3 favours the mode switch over bit 0
      '{1'b1, 4'b0101, 10, 4'b0000, 2'd0, 1'b0, 0},
      '{1'b0, 4'b0000,  8, 4'b0001, 2'd0, 1'b1, 0},
      '{1'b0, 4'b0000,  1, 4'b0101, 2'd0, 1'b1, 1},
      '{1'b0, 4'b0000,  1, 4'b0101, 2'd0, 1'b0, 2},
      '{1'b0, 4'b1001, 10, 4'b0101, 2'd0, 1'b0, 2},
      '{1'b0, 4'b0000,  8, 4'b1101, 2'd1, 1'b1, 2},
      '{1'b0, 4'b0000,  1, 4'b1100, 2'd1, 1'b1, 3},
      // mode sequencing with state 0011
      '{1'b1, 4'b0011, 10, 4'b0000, 2'd0, 1'b0, 0},
      '{1'b0, 4'b0000, 10, 4'b0011, 2'd0, 1'b0, 2},
      '{1'b0, 4'b1000, 10, 4'b0011, 2'd0, 1'b0, 2},
      '{1'b0, 4'b0000,  8, 4'b1011, 2'd1, 1'b1, 2},
      '{1'b0, 4'b0000,  7, 4'b1011, 2'd1, 1'b0, 3},
      '{1'b0, 4'b0000,  1, 4'b1000, 2'd1, 1'b0, 3},
      '{1'b0, 4'b0000,  7, 4'b1000, 2'd1, 1'b0, 3},
      '{1'b0, 4'b0000,  1, 4'b1011, 2'd1, 1'b0, 3},
      '{1'b0, 4'b1000, 10, 4'b1000, 2'd1, 1'b0, 3},
      '{1'b0, 4'b0000,  8, 4'b1001, 2'd2, 1'b1, 3},
      '{1'b0, 4'b0000,  7, 4'b1001, 2'd2, 1'b0, 4},
      '{1'b0, 4'b0000,  1, 4'b1010, 2'd2, 1'b0, 4},
      '{1'b0, 4'b0000,  8, 4'b1100, 2'd2, 1'b0, 4},
      '{1'b0, 4'b0000,  8, 4'b1001, 2'd2, 1'b0, 4},
      '{1'b0, 4'b0001, 10, 4'b1010, 2'd2, 1'b0, 4},
      '{1'b0, 4'b0000,  8, 4'b1100, 2'd2, 1'b1, 4},
      '{1'b0, 4'b0000,  1, 4'b1100, 2'd2, 1'b0, 5},
      '{1'b0, 4'b1000, 10, 4'b1001, 2'd2, 1'b0, 5},
      '{1'b0, 4'b0000,  8, 4'b0011, 2'd0, 1'b1, 5},
      '{1'b0, 4'b0000,  1, 4'b0011, 2'd0, 1'b0, 6}
    };
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      sw = tbl[i].sw;
      repeat (tbl[i].n) tick();
      chk("led", i, led, tbl[i].led);
      chk("mode", i, mode, tbl[i].mode);
      chk("evt", i, evt, tbl[i].evt);
      chk("evt_cnt", i, ev_cnt - ev_base, tbl[i].cnt);
    end
    // asynchronous reset in the middle of a debounce count
    do_reset();
    sw = 4'b1001;
    repeat (10) tick();
    sw = 4'b0001;
    repeat (8) tick();
    chk("ar_pre_mode", 0, mode, 2'd1);
    chk("ar_pre_led", 0, led, 4'b1000);
    sw = 4'b0000;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_led", 0, led, 4'b0000);
    chk("ar_mode", 0, mode, 2'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    ev_base = ev_cnt;
    repeat (20) tick();
    chk("ar_post_led", 0, led, 4'b0000);
    chk("ar_post_mode", 0, mode, 2'd0);
    chk("ar_post_cnt", 0, ev_cnt - ev_base, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
